uart_fifo_ctrl: RTL

Parametrised synchronous FIFO serving as the byte buffer between the UART receiver/transmitter datapaths and the host side. Generalises the team's first-generation queue with arbitrary (non-power-of-two) depth, selectable first-word-fall-through or registered read mode, and programmable almost-full/almost-empty thresholds. Adds an occupancy count and sticky overflow/underflow error flags. One instance sits on the RX path and one on the TX path.

---
 rtl/uart_fifo_pkg.sv | 12 +
 rtl/uart_fifo_mem.sv | 46 ++++
 rtl/uart_fifo_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART byte FIFO.
package uart_fifo_pkg;

   localparam int FWFT_MODE = 1;
   localparam int REG_MODE  = 0;

   // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, async read (FWFT) or registered read.
module uart_fifo_mem
   import uart_fifo_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = FWFT_MODE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_wr_en,
   input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
   input  logic [DATA_BITS-1:0]       i_wr_data,
   input  logic                       i_rd_en,
   input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
   output logic [DATA_BITS-1:0]       o_rd_data
);

   logic [DATA_BITS-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   generate
      if (FWFT == FWFT_MODE) begin : g_async_rd
         logic w_unused;
         assign w_unused  = &{1'b0, reset, i_rd_en};
         assign o_rd_data = r_mem[i_rd_addr];
      end else begin : g_reg_rd
         logic [DATA_BITS-1:0] r_rd_data;
         // Holds the last popped word until the next accepted read.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_rd_data <= '0;
            end else if (i_rd_en) begin
               r_rd_data <= r_mem[i_rd_addr];
            end
         end
         assign o_rd_data = r_rd_data;
      end
   endgenerate

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART byte FIFO: pointers, occupancy, status flags and sticky error flags.
module uart_fifo_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = FWFT_MODE
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en,
   input  logic [DATA_BITS-1:0]            wr_data,
   input  logic                            rd_en,
   input  logic                            clear_err,
   output logic [DATA_BITS-1:0]            rd_data,
   output logic                            rd_valid,
   output logic                            full,
   output logic                            empty,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic [level_width(DEPTH)-1:0]   level,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic                 r_overflow;
   logic                 r_underflow;
   logic                 w_rd_acc;
   logic                 w_wr_acc;
   logic                 w_wr_rej;
   logic                 w_rd_rej;
   logic [DATA_BITS-1:0] w_mem_rd_data;

   // Explicit wrap so non-power-of-two depths never alias.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty        = (r_level == '0);
   assign full         = (r_level == LVL_W'(DEPTH));
   assign almost_full  = (r_level >= LVL_W'(AFULL_THRESH));
   assign almost_empty = (r_level <= LVL_W'(AEMPTY_THRESH));
   assign level        = r_level;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // A read frees a slot the same cycle, so a full FIFO still accepts a paired write.
   always_comb begin
      w_rd_acc = !reset && rd_en && !empty;
      w_wr_acc = !reset && wr_en && (!full || w_rd_acc);
      w_wr_rej = !reset && wr_en && !w_wr_acc;
      w_rd_rej = !reset && rd_en && empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_wr_acc && w_rd_acc) begin
            r_level <= r_level - LVL_W'(1);
         end
         r_overflow  <= w_wr_rej | (r_overflow & ~clear_err);
         r_underflow <= w_rd_rej | (r_underflow & ~clear_err);
      end
   end

   uart_fifo_mem #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH),
      .FWFT      (FWFT)
   ) u_mem (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (wr_data),
      .i_rd_en   (w_rd_acc),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_rd_data)
   );

   generate
      if (FWFT == FWFT_MODE) begin : g_fwft
         assign rd_data  = empty ? '0 : w_mem_rd_data;
         assign rd_valid = !empty;
      end else begin : g_reg
         logic r_rd_valid;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
            end
         end
         assign rd_data  = w_mem_rd_data;
         assign rd_valid = r_rd_valid;
      end
   endgenerate

endmodule
